// File: rtl/liteic_pkg.sv
`default_nettype none
// ============================================================================
// liteic_pkg: shared types and constants for the liteic interconnect | Rev 1.0
// ============================================================================
package liteic_pkg;

    typedef enum logic [1:0] {
        OKAY   = 2'b00,
        EXOKAY = 2'b01,
        SLVERR = 2'b10,
        DECERR = 2'b11
    } resp_t;

    typedef enum logic [1:0] {
        W_IDLE    = 2'd0,
        W_HAVE_AW = 2'd1,
        W_HAVE_W  = 2'd2,
        W_RESP    = 2'd3
    } w_state_t;

    typedef enum logic [0:0] {
        R_IDLE = 1'b0,
        R_RESP = 1'b1
    } r_state_t;

    localparam logic [31:0] ERR_DATA_DEFAULT = 32'hDEAD_BEEF;

endpackage
`default_nettype wire

// File: rtl/liteic_sat_cnt.sv
`default_nettype none
// ============================================================================
// liteic_sat_cnt: two-source saturating counter with synchronous clear | Rev 1.0
// ============================================================================
module liteic_sat_cnt #(
    parameter int WIDTH = 16
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             inc_a,
    input  logic             inc_b,
    input  logic             clr,
    output logic [WIDTH-1:0] cnt_o
);

    localparam int SW = WIDTH + 1;

    logic [WIDTH-1:0] cnt_q;
    logic [WIDTH-1:0] cnt_d;
    logic [WIDTH:0]   w_sum;

    // One extra bit catches any overflow of a +1 or +2 step, so saturation is a single test.
    always_comb begin
        w_sum = {1'b0, cnt_q} + SW'(inc_a) + SW'(inc_b);
        cnt_d = w_sum[WIDTH] ? {WIDTH{1'b1}} : w_sum[WIDTH-1:0];
        if (clr) begin
            cnt_d = '0;
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign cnt_o = cnt_q;

endmodule
`default_nettype wire

// File: rtl/liteic_err_slave.sv
`default_nettype none
// ============================================================================
// liteic_err_slave: AXI4-Lite default slave answering DECERR, with debug status | Rev 1.0
// ============================================================================
module liteic_err_slave
    import liteic_pkg::*;
#(
    parameter int          ADDR_WIDTH = 32,
    parameter int          DATA_WIDTH = 32,
    parameter logic [31:0] ERR_DATA   = ERR_DATA_DEFAULT,
    parameter int          CNT_WIDTH  = 16
) (
    input  logic                    clk_i,
    input  logic                    rst_i,
    input  logic [ADDR_WIDTH-1:0]   awaddr_i,
    input  logic                    awvalid_i,
    output logic                    awready_o,
    input  logic [DATA_WIDTH-1:0]   wdata_i,
    input  logic [DATA_WIDTH/8-1:0] wstrb_i,
    input  logic                    wvalid_i,
    output logic                    wready_o,
    output logic [1:0]              bresp_o,
    output logic                    bvalid_o,
    input  logic                    bready_i,
    input  logic [ADDR_WIDTH-1:0]   araddr_i,
    input  logic                    arvalid_i,
    output logic                    arready_o,
    output logic [DATA_WIDTH-1:0]   rdata_o,
    output logic [1:0]              rresp_o,
    output logic                    rvalid_o,
    input  logic                    rready_i,
    output logic [ADDR_WIDTH-1:0]   err_addr_o,
    output logic [CNT_WIDTH-1:0]    err_cnt_o,
    input  logic                    cnt_clr_i
);

    w_state_t              wstate_q;
    w_state_t              wstate_d;
    r_state_t              rstate_q;
    r_state_t              rstate_d;
    logic [ADDR_WIDTH-1:0] err_addr_q;

    logic w_aw_hs;
    logic w_w_hs;
    logic w_b_hs;
    logic w_ar_hs;
    logic w_r_hs;
    logic w_unused;

    // Write data is discarded: the transaction only needs to be completed, not performed.
    assign w_unused = ^{wdata_i, wstrb_i};

    always_comb begin
        wstate_d  = wstate_q;
        awready_o = 1'b0;
        wready_o  = 1'b0;
        bvalid_o  = 1'b0;
        case (wstate_q)
            W_IDLE: begin
                awready_o = 1'b1;
                wready_o  = 1'b1;
                if (awvalid_i && wvalid_i) begin
                    wstate_d = W_RESP;
                end else if (awvalid_i) begin
                    wstate_d = W_HAVE_AW;
                end else if (wvalid_i) begin
                    wstate_d = W_HAVE_W;
                end
            end
            W_HAVE_AW: begin
                wready_o = 1'b1;
                if (wvalid_i) begin
                    wstate_d = W_RESP;
                end
            end
            W_HAVE_W: begin
                awready_o = 1'b1;
                if (awvalid_i) begin
                    wstate_d = W_RESP;
                end
            end
            W_RESP: begin
                bvalid_o = 1'b1;
                if (bready_i) begin
                    wstate_d = W_IDLE;
                end
            end
            default: wstate_d = W_IDLE;
        endcase
    end

    always_comb begin
        rstate_d  = rstate_q;
        arready_o = 1'b0;
        rvalid_o  = 1'b0;
        case (rstate_q)
            R_IDLE: begin
                arready_o = 1'b1;
                if (arvalid_i) begin
                    rstate_d = R_RESP;
                end
            end
            R_RESP: begin
                rvalid_o = 1'b1;
                if (rready_i) begin
                    rstate_d = R_IDLE;
                end
            end
            default: rstate_d = R_IDLE;
        endcase
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            wstate_q <= W_IDLE;
            rstate_q <= R_IDLE;
        end else begin
            wstate_q <= wstate_d;
            rstate_q <= rstate_d;
        end
    end

    assign w_aw_hs = awvalid_i & awready_o;
    assign w_w_hs  = wvalid_i  & wready_o;
    assign w_b_hs  = bvalid_o  & bready_i;
    assign w_ar_hs = arvalid_i & arready_o;
    assign w_r_hs  = rvalid_o  & rready_i;

    // A write address takes priority when both channels present one together.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            err_addr_q <= '0;
        end else if (w_aw_hs) begin
            err_addr_q <= awaddr_i;
        end else if (w_ar_hs) begin
            err_addr_q <= araddr_i;
        end
    end

    liteic_sat_cnt #(
        .WIDTH (CNT_WIDTH)
    ) u_err_cnt (
        .clk_i (clk_i),
        .rst_i (rst_i),
        .inc_a (w_b_hs),
        .inc_b (w_r_hs),
        .clr   (cnt_clr_i),
        .cnt_o (err_cnt_o)
    );

    assign err_addr_o = err_addr_q;
    assign bresp_o    = DECERR;
    assign rresp_o    = DECERR;
    assign rdata_o    = DATA_WIDTH'(ERR_DATA);

endmodule
`default_nettype wire

// File: tb/tb_liteic_err_slave.sv
`default_nettype none
// ============================================================================
// tb_liteic_err_slave: randomized scoreboard bench for the DECERR default slave | Rev 1.0
// ============================================================================
module tb_liteic_err_slave;

    logic        clk = 1'b0;
    logic        rst_i = 1'b1;
    logic [31:0] awaddr = '0;
    logic        awvalid = 1'b0;
    logic [31:0] wdata = '0;
    logic [3:0]  wstrb = '0;
    logic        wvalid = 1'b0;
    logic        bready = 1'b0;
    logic [31:0] araddr = '0;
    logic        arvalid = 1'b0;
    logic        rready = 1'b0;
    logic        cnt_clr = 1'b0;

    logic        awready, wready, bvalid, arready, rvalid;
    logic [1:0]  bresp, rresp;
    logic [31:0] rdata, err_addr;
    logic [15:0] err_cnt;

    logic        s_awready, s_wready, s_bvalid, s_arready, s_rvalid;
    logic [1:0]  s_bresp, s_rresp;
    logic [31:0] s_rdata, s_err_addr;
    logic [1:0]  s_err_cnt;

    always #5 clk = ~clk;

    liteic_err_slave dut (
        .clk_i(clk), .rst_i(rst_i),
        .awaddr_i(awaddr), .awvalid_i(awvalid), .awready_o(awready),
        .wdata_i(wdata), .wstrb_i(wstrb), .wvalid_i(wvalid), .wready_o(wready),
        .bresp_o(bresp), .bvalid_o(bvalid), .bready_i(bready),
        .araddr_i(araddr), .arvalid_i(arvalid), .arready_o(arready),
        .rdata_o(rdata), .rresp_o(rresp), .rvalid_o(rvalid), .rready_i(rready),
        .err_addr_o(err_addr), .err_cnt_o(err_cnt), .cnt_clr_i(cnt_clr)
    );

    // Narrow-counter copy sharing every input, to exercise saturation.
    liteic_err_slave #(.CNT_WIDTH(2)) dut_s (
        .clk_i(clk), .rst_i(rst_i),
        .awaddr_i(awaddr), .awvalid_i(awvalid), .awready_o(s_awready),
        .wdata_i(wdata), .wstrb_i(wstrb), .wvalid_i(wvalid), .wready_o(s_wready),
        .bresp_o(s_bresp), .bvalid_o(s_bvalid), .bready_i(bready),
        .araddr_i(araddr), .arvalid_i(arvalid), .arready_o(s_arready),
        .rdata_o(s_rdata), .rresp_o(s_rresp), .rvalid_o(s_rvalid), .rready_i(rready),
        .err_addr_o(s_err_addr), .err_cnt_o(s_err_cnt), .cnt_clr_i(cnt_clr)
    );

    typedef struct packed {
        logic [1:0]  resp;
        logic [31:0] data;
    } exp_t;

    exp_t bq[$];
    exp_t rq[$];

    int checks   = 0;
    int failures = 0;

    // Transaction-level model: which halves of a write are held, which responses are owed.
    bit          m_have_aw, m_have_w, m_b_owed, m_r_owed;
    logic [31:0] m_addr;
    int          m_cnt, m_cnt_s;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic model_clear();
        m_have_aw = 0; m_have_w = 0; m_b_owed = 0; m_r_owed = 0;
        m_addr = '0; m_cnt = 0; m_cnt_s = 0;
        bq.delete(); rq.delete();
    endtask

    task automatic check_outputs();
        chk("awready",  awready,  !m_have_aw && !m_b_owed);
        chk("wready",   wready,   !m_have_w  && !m_b_owed);
        chk("arready",  arready,  !m_r_owed);
        chk("bvalid",   bvalid,   m_b_owed);
        chk("rvalid",   rvalid,   m_r_owed);
        chk("err_addr", err_addr, m_addr);
        chk("err_cnt",  err_cnt,  m_cnt);
        chk("s_handshake", {s_awready, s_wready, s_arready, s_bvalid, s_rvalid},
            {!m_have_aw && !m_b_owed, !m_have_w && !m_b_owed, !m_r_owed, m_b_owed, m_r_owed});
        chk("s_err_addr", s_err_addr, m_addr);
        chk("s_err_cnt",  s_err_cnt,  m_cnt_s);
    endtask

    task automatic step(input logic awv, input logic [31:0] awa, input logic wv,
                        input logic arv, input logic [31:0] ara,
                        input logic br, input logic rr, input logic clr);
        bit aw_hs, w_hs, ar_hs, b_hs, r_hs;
        int nc;
        @(posedge clk); #1;
        check_outputs();
        awvalid = awv; awaddr = awa; wvalid = wv; arvalid = arv; araddr = ara;
        bready = br; rready = rr; cnt_clr = clr;
        wdata = $urandom; wstrb = 4'($urandom);

        aw_hs = awv && !m_have_aw && !m_b_owed;
        w_hs  = wv  && !m_have_w  && !m_b_owed;
        ar_hs = arv && !m_r_owed;
        b_hs  = m_b_owed && br;
        r_hs  = m_r_owed && rr;

        if (b_hs) begin
            m_b_owed = 0;
        end else begin
            m_have_aw = m_have_aw || aw_hs;
            m_have_w  = m_have_w  || w_hs;
            if (m_have_aw && m_have_w) begin
                m_have_aw = 0; m_have_w = 0; m_b_owed = 1;
                bq.push_back('{resp: 2'b11, data: 32'h0});
            end
        end
        if (r_hs) begin
            m_r_owed = 0;
        end else if (ar_hs) begin
            m_r_owed = 1;
            rq.push_back('{resp: 2'b11, data: 32'hDEAD_BEEF});
        end

        if (aw_hs)      m_addr = awa;
        else if (ar_hs) m_addr = ara;

        nc = int'(b_hs) + int'(r_hs);
        if (clr) begin
            m_cnt = 0; m_cnt_s = 0;
        end else begin
            m_cnt   = (m_cnt + nc > 65535) ? 65535 : m_cnt + nc;
            m_cnt_s = (m_cnt_s + nc > 3) ? 3 : m_cnt_s + nc;
        end
    endtask

    task automatic idle(input logic br);
        step(1'b0, 32'h0, 1'b0, 1'b0, 32'h0, br, 1'b1, 1'b0);
    endtask

    task automatic do_reset();
        @(posedge clk); #1;
        check_outputs();
        rst_i = 1'b1;
        awvalid = 1'b0; wvalid = 1'b0; arvalid = 1'b0;
        #1;
        chk("rst_async_valids", {bvalid, rvalid, s_bvalid}, 3'b000);
        chk("rst_async_readys", {awready, wready, arready}, 3'b111);
        chk("rst_async_status", {err_addr, err_cnt}, 48'h0);
        model_clear();
        repeat (2) @(posedge clk);
        #1;
        rst_i = 1'b0;
    endtask

    // Monitor: pops the owed response whenever a B or R handshake is presented.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (!rst_i) begin
                if (bvalid && bready) begin
                    if (bq.size() == 0) begin
                        checks++; failures++;
                        $display("FAIL b_unexpected: got a B response, expected none (t=%0t)", $time);
                    end else begin
                        e = bq.pop_front();
                        chk("bresp", {bresp, s_bresp}, {e.resp, e.resp});
                    end
                end
                if (rvalid && rready) begin
                    if (rq.size() == 0) begin
                        checks++; failures++;
                        $display("FAIL r_unexpected: got an R response, expected none (t=%0t)", $time);
                    end else begin
                        e = rq.pop_front();
                        chk("rresp", {rresp, s_rresp}, {e.resp, e.resp});
                        chk("rdata", {rdata, s_rdata}, {e.data, e.data});
                    end
                end
            end
        end
    end

    initial begin
        model_clear();
        repeat (3) @(posedge clk);
        #1;
        rst_i = 1'b0;

        // Same-cycle AW and W, immediate B acceptance.
        idle(1'b1);
        step(1'b1, 32'h0100_0000, 1'b1, 1'b0, 32'h0, 1'b1, 1'b1, 1'b0);
        repeat (2) idle(1'b1);

        // W first, AW three cycles later, B stalled five cycles.
        step(1'b0, 32'h0, 1'b1, 1'b0, 32'h0, 1'b0, 1'b1, 1'b0);
        repeat (2) idle(1'b0);
        step(1'b1, 32'h0300_0010, 1'b0, 1'b0, 32'h0, 1'b0, 1'b1, 1'b0);
        repeat (5) idle(1'b0);
        repeat (2) idle(1'b1);

        // Read alongside a write in the same cycle; B and R then complete together.
        step(1'b1, 32'h0200_0000, 1'b1, 1'b1, 32'h0F00_0004, 1'b1, 1'b1, 1'b0);
        repeat (2) idle(1'b1);

        // Clear coinciding with a completion.
        step(1'b1, 32'h0400_0000, 1'b1, 1'b0, 32'h0, 1'b1, 1'b1, 1'b0);
        step(1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 1'b1, 1'b1, 1'b1);
        idle(1'b1);

        // Reset while a write response is pending.
        step(1'b1, 32'h0500_0000, 1'b1, 1'b1, 32'h0600_0000, 1'b0, 1'b0, 1'b0);
        idle(1'b0);
        do_reset();

        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 599) == 0) begin
                do_reset();
            end else begin
                step(1'($urandom_range(0, 1)), $urandom, 1'($urandom_range(0, 1)),
                     1'($urandom_range(0, 1)), $urandom,
                     ($urandom_range(0, 3) != 0), ($urandom_range(0, 3) != 0),
                     ($urandom_range(0, 31) == 0));
            end
        end

        repeat (4) idle(1'b1);
        @(posedge clk); #1;
        chk("bq_drained", bq.size(), 0);
        chk("rq_drained", rq.size(), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
